// File: rtl/sdf_delay_ctrl.sv
// Counting sequencer for the delay-line FIFO of one radix-2 SDF FFT stage.
// Optional FIFO protocol checking is built when SDF_CTRL_ERR_CHECK_EN is defined.
module sdf_delay_ctrl #(
  parameter int DEPTH_LOG2     = 12,
  parameter int TF_ADDR_LEN    = 12,
  parameter int TF_STRIDE_LOG2 = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic                   in_sop,
  input  logic                   fifo_full,
  input  logic                   fifo_empty,
  output logic                   fifo_wr_en,
  output logic                   fifo_rd_en,
  output logic                   fifo_clr,
  output logic                   pair_valid,
  output logic [TF_ADDR_LEN-1:0] tf_addr,
  output logic                   phase,
  output logic                   busy,
  output logic                   err
);

  localparam int CW = (DEPTH_LOG2 > 0) ? DEPTH_LOG2 : 1;
  localparam int WW = CW + TF_STRIDE_LOG2 + TF_ADDR_LEN;
  localparam logic [CW-1:0] CNT_LAST = CW'((1 << DEPTH_LOG2) - 1);
  localparam logic [CW-1:0] CNT_AFTER_SOP = (DEPTH_LOG2 == 0) ? '0 : CW'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    PAIR = 2'd2
  } state_t;

  // A D=1 stage has a one-sample FILL half, so the sop sample already ends it.
  localparam state_t STATE_AFTER_SOP = (DEPTH_LOG2 == 0) ? PAIR : FILL;

  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [CW-1:0]          idx_q, idx_d;
  logic                   wr_q, wr_d;
  logic                   rd_q, rd_d;
  logic                   clr_q, clr_d;
  logic                   pend_wr_q, pend_wr_d;
  logic                   pv_q, pv_d;
  logic [TF_ADDR_LEN-1:0] tf_q, tf_d;
  logic                   phase_q, phase_d;
  logic                   cnt_last;

  assign cnt_last = (cnt_q == CNT_LAST);

  // NOTE: every always_comb output gets a default first, so no path can leave
  // a signal unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    phase_d   = phase_q;
    wr_d      = pend_wr_q;
    rd_d      = 1'b0;
    clr_d     = 1'b0;
    pend_wr_d = 1'b0;
    pv_d      = rd_q;
    tf_d      = rd_q ? TF_ADDR_LEN'(WW'(idx_q) << TF_STRIDE_LOG2) : tf_q;

    if (in_valid) begin
      if (in_sop) begin
        state_d = STATE_AFTER_SOP;
        cnt_d   = CNT_AFTER_SOP;
        phase_d = 1'b0;
        // A restart flushes the FIFO first; the sop write trails the clear.
        if (state_q == IDLE) begin
          wr_d = 1'b1;
        end else begin
          clr_d     = 1'b1;
          pend_wr_d = 1'b1;
        end
      end else begin
        unique case (state_q)
          FILL: begin
            wr_d    = 1'b1;
            phase_d = 1'b0;
            cnt_d   = cnt_last ? '0 : cnt_q + 1'b1;
            if (cnt_last) state_d = PAIR;
          end
          PAIR: begin
            rd_d    = 1'b1;
            idx_d   = cnt_q;
            phase_d = 1'b1;
            cnt_d   = cnt_last ? '0 : cnt_q + 1'b1;
            if (cnt_last) state_d = FILL;
          end
          default: ;
        endcase
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      wr_q      <= 1'b0;
      rd_q      <= 1'b0;
      clr_q     <= 1'b0;
      pend_wr_q <= 1'b0;
      pv_q      <= 1'b0;
      tf_q      <= '0;
      phase_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      clr_q     <= clr_d;
      pend_wr_q <= pend_wr_d;
      pv_q      <= pv_d;
      tf_q      <= tf_d;
      phase_q   <= phase_d;
    end
  end

  assign fifo_wr_en = wr_q;
  assign fifo_rd_en = rd_q;
  assign fifo_clr   = clr_q;
  assign pair_valid = pv_q;
  assign tf_addr    = tf_q;
  assign phase      = phase_q;
  assign busy       = (state_q != IDLE);

`ifdef SDF_CTRL_ERR_CHECK_EN
  logic err_q, err_d;

  // Flags are compared in the same cycle the strobe reaches the FIFO.
  always_comb begin
    err_d = err_q | (wr_q & fifo_full) | (rd_q & fifo_empty);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end

  assign err = err_q;
`else
  logic unused_flags;
  assign unused_flags = fifo_full ^ fifo_empty;
  assign err          = 1'b0;
`endif

endmodule
